// File: rtl/fft32_pkg.sv
// Shared definitions for the 32-point radix-2 DIT FFT control path:
// frame geometry, sequencer states and the bit-reversal helper.
package fft32_pkg;

  localparam int N_POINTS    = 32;
  localparam int ADDR_W      = 5;
  localparam int N_STAGES    = 5;
  localparam int STAGE_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_UNLOAD  = 2'd3
  } state_e;

  // Input samples land in bit-reversed order so the DIT stages can run in place
  function automatic logic [ADDR_W-1:0] bitrev5(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = 5'd0;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft32_stage_timer.sv
// Stage/latency timer for the butterfly array: launches each stage, waits out
// the butterfly pipeline, strobes the write-back and steps the stage select.
module fft32_stage_timer
  import fft32_pkg::*;
#(
  parameter int BFLY_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   go,
  output logic                   bfly_en,
  output logic                   stage_wr,
  output logic [STAGE_SEL_W-1:0] stage_sel,
  output logic                   last_stage
);

  localparam logic [2:0]             LAT_C   = 3'(BFLY_LAT);
  localparam logic [STAGE_SEL_W-1:0] LAST_ST = 3'(N_STAGES - 1);

  logic                   active_r;
  logic [2:0]             wait_r;
  logic [STAGE_SEL_W-1:0] stage_r;
  logic                   bfly_en_r;
  logic                   stage_wr_r;

  assign bfly_en    = bfly_en_r;
  assign stage_wr   = stage_wr_r;
  assign stage_sel  = stage_r;
  assign last_stage = stage_wr_r & (stage_r == LAST_ST);

  // Per-stage sequencing; strobes are registered one cycle ahead of their use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r   <= 1'b0;
      wait_r     <= 3'd0;
      stage_r    <= 3'd0;
      bfly_en_r  <= 1'b0;
      stage_wr_r <= 1'b0;
    end else if (clear) begin
      active_r   <= 1'b0;
      wait_r     <= 3'd0;
      stage_r    <= 3'd0;
      bfly_en_r  <= 1'b0;
      stage_wr_r <= 1'b0;
    end else if (go) begin
      active_r   <= 1'b1;
      wait_r     <= 3'd0;
      stage_r    <= 3'd0;
      bfly_en_r  <= 1'b1;
      stage_wr_r <= 1'b0;
    end else if (active_r) begin
      if (wait_r == LAT_C) begin
        wait_r     <= 3'd0;
        stage_wr_r <= 1'b0;
        if (stage_r == LAST_ST) begin
          active_r  <= 1'b0;
          stage_r   <= 3'd0;
          bfly_en_r <= 1'b0;
        end else begin
          stage_r   <= stage_r + 3'd1;
          bfly_en_r <= 1'b1;
        end
      end else begin
        wait_r     <= wait_r + 3'd1;
        bfly_en_r  <= 1'b0;
        stage_wr_r <= ((wait_r + 3'd1) == LAT_C);
      end
    end else begin
      wait_r     <= 3'd0;
      stage_r    <= 3'd0;
      bfly_en_r  <= 1'b0;
      stage_wr_r <= 1'b0;
    end
  end

endmodule

// File: rtl/fft32_stage_sequencer.sv
// Frame sequencer for the iterative 32-point FFT: bit-reversed load, five
// butterfly stages via the stage timer, then natural-order unload.
module fft32_stage_sequencer
  import fft32_pkg::*;
#(
  parameter int BFLY_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ADDR_W-1:0]      in_addr,
  output logic                   in_wr_en,
  output logic [STAGE_SEL_W-1:0] stage_sel,
  output logic                   bfly_en,
  output logic                   stage_wr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = 5'd31;

  state_e            st_r;
  logic [ADDR_W-1:0] ld_cnt_r;
  logic [ADDR_W-1:0] ul_cnt_r;
  logic [ADDR_W-1:0] in_addr_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              go_s;
  logic              last_stage_s;

  assign go_s      = (st_r == ST_LOAD) & in_valid & (ld_cnt_r == LAST_IDX);
  assign in_ready  = in_ready_r;
  assign in_addr   = in_addr_r;
  assign in_wr_en  = in_valid & in_ready_r;
  assign out_valid = out_valid_r;
  assign out_addr  = ul_cnt_r;
  assign busy      = busy_r;
  // The final handshake completes the frame unless an abort lands on it
  assign done      = out_valid_r & out_ready & (ul_cnt_r == LAST_IDX) & ~clear;

  fft32_stage_timer #(
    .BFLY_LAT (BFLY_LAT)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .go         (go_s),
    .bfly_en    (bfly_en),
    .stage_wr   (stage_wr),
    .stage_sel  (stage_sel),
    .last_stage (last_stage_s)
  );

  // Frame FSM with load/unload counters and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r        <= ST_IDLE;
      ld_cnt_r    <= 5'd0;
      ul_cnt_r    <= 5'd0;
      in_addr_r   <= 5'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (clear) begin
      st_r        <= ST_IDLE;
      ld_cnt_r    <= 5'd0;
      ul_cnt_r    <= 5'd0;
      in_addr_r   <= 5'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (st_r)
        ST_IDLE: begin
          if (start) begin
            st_r       <= ST_LOAD;
            ld_cnt_r   <= 5'd0;
            in_addr_r  <= 5'd0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (ld_cnt_r == LAST_IDX) begin
              st_r       <= ST_COMPUTE;
              ld_cnt_r   <= 5'd0;
              in_addr_r  <= 5'd0;
              in_ready_r <= 1'b0;
            end else begin
              ld_cnt_r   <= ld_cnt_r + 5'd1;
              in_addr_r  <= bitrev5(ld_cnt_r + 5'd1);
            end
          end else begin
            ld_cnt_r <= ld_cnt_r;
          end
        end
        ST_COMPUTE: begin
          if (last_stage_s) begin
            st_r        <= ST_UNLOAD;
            ul_cnt_r    <= 5'd0;
            out_valid_r <= 1'b1;
          end else begin
            st_r <= ST_COMPUTE;
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (ul_cnt_r == LAST_IDX) begin
              st_r        <= ST_IDLE;
              ul_cnt_r    <= 5'd0;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
            end else begin
              ul_cnt_r <= ul_cnt_r + 5'd1;
            end
          end else begin
            ul_cnt_r <= ul_cnt_r;
          end
        end
        default: begin
          st_r        <= ST_IDLE;
          ld_cnt_r    <= 5'd0;
          ul_cnt_r    <= 5'd0;
          in_addr_r   <= 5'd0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule
